spart_bus_ctrl: RTL

//  Processor-side controller for the SPART. Decodes 2-bit I/O address strobes from the CPU,

---
 rtl/spart_pkg.sv | 14 +
 rtl/spart_bus_ctrl_if.sv | 32 +++
 rtl/spart_tx_fifo.sv | 36 +++
 rtl/spart_bus_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// spart_pkg: shared constants for the SPART bus controller.
// Holds the I/O address map, status bit positions, the load FSM states and the reset divisor.
package spart_pkg;
    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;
    localparam int ST_RDA  = 0;
    localparam int ST_TBR  = 1;
    localparam int ST_OVR  = 3;
    localparam int ST_BUSY = 4;
    localparam logic [15:0] DEFAULT_DIV = 16'h028C;
    typedef enum logic [1:0] {LD_IDLE, LD_LOAD, LD_SETTLE} ld_state_t;
endpackage

// File: rtl/spart_bus_ctrl_if.sv
// spart_bus_ctrl_if: bundles the CPU I/O bus and the BRG/TX/RX links of the bus controller.
// CPU side:  iocs, iorw, ioaddr, db_in -> controller; db_out, db_oe <- controller.
// BRG side:  brg_db, brg_load <- controller.
// TX side:   tx_busy -> controller; tx_start, tx_data <- controller.
// RX side:   rx_valid, rx_data -> controller.
// Flags:     rda, tbr <- controller.
// slave is the controller's view; master is the view of whatever drives it.
interface spart_bus_ctrl_if;
    logic        iocs;
    logic        iorw;
    logic [1:0]  ioaddr;
    logic [7:0]  db_in;
    logic [7:0]  db_out;
    logic        db_oe;
    logic [15:0] brg_db;
    logic        brg_load;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rda;
    logic        tbr;
    modport slave (
        input  iocs, iorw, ioaddr, db_in, tx_busy, rx_valid, rx_data,
        output db_out, db_oe, brg_db, brg_load, tx_start, tx_data, rda, tbr
    );
    modport master (
        output iocs, iorw, ioaddr, db_in, tx_busy, rx_valid, rx_data,
        input  db_out, db_oe, brg_db, brg_load, tx_start, tx_data, rda, tbr
    );
endinterface

// File: rtl/spart_tx_fifo.sv
// spart_tx_fifo: circular TX byte queue with wrap-bit pointers.
// Ports: clk, rst (async active-low), push/din enqueue, pop dequeue,
//        head = oldest entry, full/empty flags. DEPTH must be a power of 2 (>=2).
// Push while full is accepted only when paired with a pop; the caller gates that.
module spart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;
    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign head  = mem[rp[AW-1:0]];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/spart_bus_ctrl.sv
// spart_bus_ctrl: CPU-side SPART controller - address decode, divisor staging, BRG load sequencing, TX queue, RX hand-off.
// Ports: clk; rst (async active-low); bus (spart_bus_ctrl_if.slave) carrying the CPU I/O bus,
//        brg_db/brg_load to the baud generator, tx_busy/tx_start/tx_data to the transmitter,
//        rx_valid/rx_data from the receiver and the rda/tbr flags.
// Build option: SPART_TX_FIFO_EN selects a TX_FIFO_DEPTH-entry FIFO instead of a single holding register.
module spart_bus_ctrl #(
    parameter logic [15:0] DEFAULT_DIV   = spart_pkg::DEFAULT_DIV,
    parameter int          LOAD_HOLD     = 4,
    parameter int          TX_FIFO_DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    spart_bus_ctrl_if.slave   bus
);
    import spart_pkg::*;
    if (LOAD_HOLD < 3 || LOAD_HOLD > 255 || TX_FIFO_DEPTH < 2 || (TX_FIFO_DEPTH & (TX_FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("spart_bus_ctrl: LOAD_HOLD must be 3..255 and TX_FIFO_DEPTH a power of 2 >= 2");
    end
    ld_state_t   state, nxt;
    logic [7:0]  cnt;
    logic [15:0] pend, brg_db_q;
    logic        pend_v;
    logic [7:0]  lo_shadow, rx_buf, tx_data_q, tq_head, stat;
    logic        rda_q, ovr, tx_start_q;
    logic        wr, rd, wr_buf, wr_dbl, wr_dbh, rd_buf, rd_stat;
    logic        busy_ld, go, push, drop, pop, tq_empty, tbr_w;
    assign wr      = bus.iocs & ~bus.iorw;
    assign rd      = bus.iocs & bus.iorw;
    assign wr_buf  = wr & (bus.ioaddr == ADDR_BUF);
    assign wr_dbl  = wr & (bus.ioaddr == ADDR_DBL);
    assign wr_dbh  = wr & (bus.ioaddr == ADDR_DBH);
    assign rd_buf  = rd & (bus.ioaddr == ADDR_BUF);
    assign rd_stat = rd & (bus.ioaddr == ADDR_STAT);
    assign busy_ld = state != LD_IDLE;
    assign go      = (state == LD_IDLE) & pend_v;
    // pend_v comes out of reset set with pend = DEFAULT_DIV, so the first IDLE cycle launches a load on its own.
    always_comb begin
        nxt = (state == LD_IDLE) ? (pend_v ? LD_LOAD : LD_IDLE) :
              (cnt != 8'd0)      ? state :
              (state == LD_LOAD) ? LD_SETTLE : LD_IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= LD_IDLE;
        else state <= nxt;
    end
    // cnt counts LOAD_HOLD cycles in LOAD, then is reused for the 2-cycle SETTLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            brg_db_q  <= DEFAULT_DIV;
            pend      <= DEFAULT_DIV;
            pend_v    <= 1'b1;
            lo_shadow <= '0;
        end else begin
            if (wr_dbl) lo_shadow <= bus.db_in;
            if (wr_dbh) pend <= {bus.db_in, lo_shadow};
            pend_v <= wr_dbh | (pend_v & ~go);
            if (go) begin
                brg_db_q <= pend;
                cnt      <= 8'(LOAD_HOLD - 1);
            end else if (state == LD_LOAD && cnt == 8'd0) cnt <= 8'd1;
            else if (busy_ld) cnt <= cnt - 8'd1;
        end
    end
    assign pop = ~tq_empty & ~bus.tx_busy & ~tx_start_q;
`ifdef SPART_TX_FIFO_EN
    logic tq_full;
    assign push  = wr_buf & (~tq_full | pop);
    assign drop  = wr_buf & tq_full & ~pop;
    assign tbr_w = ~tq_full;
    spart_tx_fifo #(.DEPTH(TX_FIFO_DEPTH), .W(8)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.db_in),
        .head  (tq_head),
        .full  (tq_full),
        .empty (tq_empty)
    );
`else
    logic hold_v;
    assign push     = wr_buf & ~hold_v;
    assign drop     = wr_buf & hold_v;
    assign tbr_w    = ~hold_v;
    assign tq_empty = ~hold_v;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_v  <= 1'b0;
            tq_head <= '0;
        end else begin
            if (push) tq_head <= bus.db_in;
            hold_v <= push | (hold_v & ~pop);
        end
    end
`endif
    // Set events (dropped TX write, RX overrun) take priority over the status-read clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            rx_buf     <= '0;
            rda_q      <= 1'b0;
            ovr        <= 1'b0;
        end else begin
            tx_start_q <= pop;
            if (pop) tx_data_q <= tq_head;
            if (bus.rx_valid) rx_buf <= bus.rx_data;
            rda_q <= bus.rx_valid | (rda_q & ~rd_buf);
            ovr   <= drop | (bus.rx_valid & rda_q) | (ovr & ~rd_stat);
        end
    end
    always_comb begin
        stat           = '0;
        stat[ST_RDA]   = rda_q;
        stat[ST_TBR]   = tbr_w;
        stat[ST_OVR]   = ovr;
        stat[ST_BUSY]  = pend_v | busy_ld;
    end
    assign bus.db_out   = (bus.ioaddr == ADDR_BUF)  ? rx_buf :
                          (bus.ioaddr == ADDR_STAT) ? stat :
                          (bus.ioaddr == ADDR_DBL)  ? lo_shadow : brg_db_q[15:8];
    assign bus.db_oe    = rd;
    assign bus.brg_db   = brg_db_q;
    assign bus.brg_load = state == LD_LOAD;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.rda      = rda_q;
    assign bus.tbr      = tbr_w;
endmodule
